ifu_prefetch_queue: RTL and testbench
=====================================

// Module: ifu_prefetch_queue
// PURPOSE
//  Next-generation instruction fetch unit. Keeps up to MAX_OUT single-beat AXI4 reads in flight on
//  sequential PCs and buffers returned instructions in a DEPTH-entry FIFO. Delivers {pc, inst, fault}
//  to the IDU over a valid/ready handshake. Sits between the PC redirect source (EXU/branch) and IDU.
//  Redirects flush the queue; responses to requests already in flight are discarded.
// PARAMETERS
//  ADDR_W    32            fetch address width
//  INST_W    32            instruction / rdata width (power of 2, >= 32)
//  DEPTH     4             FIFO entries (power of 2, >= 2)
//  MAX_OUT   2             max outstanding AR requests (1..DEPTH)
//  RESET_PC  32'h8000_0000 first fetch address after reset
//  AXI_ID    4'd0          constant arid; responses with rid != AXI_ID are ignored (rready still 1)
// PORTS
//  clk          in   1       clock
//  rst          in   1       synchronous, active-high reset
//  redirect     in   1       flush queue, restart fetch at redirect_pc
//  redirect_pc  in   ADDR_W  new fetch address (low 2 bits ignored, forced to 0)
//  stall        in   1       inhibit new AR issue (in-flight and buffered data unaffected)
//  out_valid    out  1       instruction available to IDU
//  out_ready    in   1       IDU accepts
//  out_pc       out  ADDR_W  pc of out_inst
//  out_inst     out  INST_W  instruction word
//  out_fault    out  1       rresp != OKAY for this word
//  arvalid/arready  out/in 1 AXI read address handshake
//  araddr       out  ADDR_W  fetch address
//  arid/arlen/arsize/arburst out 4/8/3/2  AXI_ID / 0 / log2(INST_W/8) / INCR
//  rvalid/rready    in/out 1 AXI read data handshake
//  rdata/rresp/rlast/rid  in  INST_W/2/1/4  read data channel
// BEHAVIOUR
//  Reset: arvalid=0, out_valid=0, FIFO empty, outstanding=0, drop_cnt=0, fetch_pc=RESET_PC,
//   resp_pc=RESET_PC. rready=1 in every cycle after reset (space is reserved at issue).
//  Issue: arvalid rises next cycle when !stall && !redirect && outstanding+fifo_count < DEPTH &&
//   outstanding < MAX_OUT. araddr=fetch_pc. arvalid/araddr held stable until arready (AXI rule),
//   regardless of stall/redirect. On AR handshake: outstanding++, fetch_pc += INST_W/8.
//   Back-to-back issue allowed: arvalid stays 1 across consecutive handshakes if limits permit.
//  Response (rvalid&rready&rid==AXI_ID): outstanding--. If drop_cnt>0: drop_cnt--, data discarded.
//   Else push {resp_pc, rdata, rresp!=OKAY} to FIFO, resp_pc += INST_W/8. rlast ignored (arlen=0).
//  Output: out_* = FIFO head, registered; first-word latency = 1 cycle after R handshake.
//   out_valid&out_ready pops. Simultaneous push/pop legal at any occupancy, including full.
//  Redirect (1-cycle pulse, highest priority): FIFO cleared, out_valid=0 next cycle (pop this cycle
//   ignored). drop_cnt <= outstanding + (AR handshake this cycle) - (R handshake this cycle).
//   fetch_pc=resp_pc=redirect_pc. If arvalid pending without arready, that request completes its
//   handshake, is counted in drop_cnt, then the new stream issues.
//  Redirect in same cycle as a non-dropped response: response discarded.
//  Credit rule guarantees no FIFO overflow; overflow/underflow is a design bug (assertion).
//  fetch_pc/resp_pc wrap modulo 2^ADDR_W.
//  rst mid-transaction: all state cleared; interconnect is reset by the same rst.
// STRUCTURE
//  Package ifu_pkg: AXI_BURST_INCR, AXI_RESP_OKAY, size encoding fn, fetch entry struct {pc,inst,fault}.
//  Sub-module ifu_fifo (sync FIFO, DEPTH x entry, count output, clear input). Counters in top.
// TESTING
//  1. Reset, arready=rvalid=1, 1-cycle memory: araddr 0x80000000,04,08..; IDU sees pc/inst in order,
//     steady state 1 inst/cycle with MAX_OUT=2.
//  2. out_ready=0 forever: exactly DEPTH ARs issued, FIFO full, arvalid stays 0, no data lost.
//  3. Redirect to 0x80001000 with 2 outstanding: both responses dropped, next out_pc=0x80001000.
//  4. Redirect while arvalid=1, arready=0 for 3 cycles: araddr unchanged until handshake, that
//     response dropped, then fetch restarts at redirect_pc.
//  5. rresp=SLVERR on pc 0x80000008: out_fault=1 only for that entry.
//  6. stall=1 for 10 cycles: no new AR, buffered entries still drain; rst mid-burst -> reset values.

Source files
------------

// File: rtl/ifu_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ifu_pkg : shared AXI encodings and fetch-entry types for the instruction fetch unit
// Rev 1.0
// ----------------------------------------------------------------------------
package ifu_pkg;

   localparam int IFU_ADDR_W = 32;
   localparam int IFU_INST_W = 32;

   localparam logic [1:0] AXI_BURST_INCR = 2'b01;
   localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

   // Entry as seen by the IDU in the default fetch geometry.
   typedef struct packed {
      logic [IFU_ADDR_W-1:0] pc;
      logic [IFU_INST_W-1:0] inst;
      logic                  fault;
   } fetch_entry_t;

   function automatic logic [2:0] axi_size(input int unsigned inst_w);
      return 3'($clog2(inst_w / 8));
   endfunction

endpackage
`default_nettype wire

// File: rtl/ifu_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ifu_fifo : synchronous FIFO with occupancy count and single-cycle clear
// Rev 1.0
// ----------------------------------------------------------------------------
module ifu_fifo #(
   parameter int WIDTH = 65,
   parameter int DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         clear,
   input  logic                         push,
   input  logic [WIDTH-1:0]             wdata,
   input  logic                         pop,
   output logic [WIDTH-1:0]             rdata,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             full;

   assign full  = (count_q == CW'(DEPTH));
   assign rdata = mem_q[rd_ptr_q];
   assign count = count_q;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (clear) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         // When full, wr_ptr equals rd_ptr: the head is read this cycle before being overwritten.
         if (push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + PW'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
         end
         count_d = count_q + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assert property (@(posedge clk) disable iff (rst) !(push && !pop && !clear && full));
   assert property (@(posedge clk) disable iff (rst) !(pop && !clear && (count_q == '0)));

endmodule
`default_nettype wire

// File: rtl/ifu_prefetch_queue.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ifu_prefetch_queue : credit-limited AXI4 sequential prefetcher feeding the IDU through a FIFO
// Rev 1.0
// ----------------------------------------------------------------------------
module ifu_prefetch_queue
   import ifu_pkg::*;
#(
   parameter int                 ADDR_W   = IFU_ADDR_W,
   parameter int                 INST_W   = IFU_INST_W,
   parameter int                 DEPTH    = 4,
   parameter int                 MAX_OUT  = 2,
   parameter logic [ADDR_W-1:0]  RESET_PC = 32'h8000_0000,
   parameter logic [3:0]         AXI_ID   = 4'd0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              redirect,
   input  logic [ADDR_W-1:0] redirect_pc,
   input  logic              stall,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ADDR_W-1:0] out_pc,
   output logic [INST_W-1:0] out_inst,
   output logic              out_fault,
   output logic              arvalid,
   input  logic              arready,
   output logic [ADDR_W-1:0] araddr,
   output logic [3:0]        arid,
   output logic [7:0]        arlen,
   output logic [2:0]        arsize,
   output logic [1:0]        arburst,
   input  logic              rvalid,
   output logic              rready,
   input  logic [INST_W-1:0] rdata,
   input  logic [1:0]        rresp,
   input  logic              rlast,
   input  logic [3:0]        rid
);

   localparam int                CW        = $clog2(DEPTH+1);
   localparam int                SW        = CW + 1;
   localparam logic [ADDR_W-1:0] STEP      = ADDR_W'(INST_W / 8);
   localparam logic [SW-1:0]     DEPTH_C   = SW'(DEPTH);
   localparam logic [CW-1:0]     MAX_OUT_C = CW'(MAX_OUT);

   typedef struct packed {
      logic [ADDR_W-1:0] pc;
      logic [INST_W-1:0] inst;
      logic              fault;
   } entry_t;

   logic              arvalid_q, arvalid_d;
   logic [ADDR_W-1:0] araddr_q, araddr_d;
   logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
   logic [ADDR_W-1:0] resp_pc_q, resp_pc_d;
   logic [CW-1:0]     outstanding_q, outstanding_d;
   logic [CW-1:0]     drop_cnt_q, drop_cnt_d;

   logic              ar_hs, r_hs, hold, push, pop;
   logic [CW-1:0]     fifo_count;
   logic [SW-1:0]     credit_used;
   logic [ADDR_W-1:0] redirect_base;
   entry_t            wr_entry, rd_entry;
   logic              unused_bits;

   assign ar_hs         = arvalid_q && arready;
   assign r_hs          = rvalid && (rid == AXI_ID);
   assign hold          = arvalid_q && !arready;
   assign push          = r_hs && (drop_cnt_q == '0) && !redirect;
   assign pop           = out_valid && out_ready && !redirect;
   assign redirect_base = {redirect_pc[ADDR_W-1:2], 2'b00};
   assign unused_bits   = ^{rlast, redirect_pc[1:0]};
   assign wr_entry      = '{pc: resp_pc_q, inst: rdata, fault: (rresp != AXI_RESP_OKAY)};

   always_comb begin
      arvalid_d     = arvalid_q;
      araddr_d      = araddr_q;
      fetch_pc_d    = fetch_pc_q;
      resp_pc_d     = resp_pc_q;
      drop_cnt_d    = drop_cnt_q;
      outstanding_d = outstanding_q + CW'(ar_hs) - CW'(r_hs);
      // Every in-flight request holds a FIFO slot, so responses can never overflow the queue.
      credit_used   = {1'b0, outstanding_d}
                    + (redirect ? '0 : ({1'b0, fifo_count} + SW'(push) - SW'(pop)));

      if (r_hs && (drop_cnt_q != '0)) begin
         drop_cnt_d = drop_cnt_q - CW'(1);
      end
      if (push) begin
         resp_pc_d = resp_pc_q + STEP;
      end

      if (hold) begin
         arvalid_d = 1'b1;
      end else if (!stall && !redirect && (credit_used < DEPTH_C) && (outstanding_d < MAX_OUT_C)) begin
         arvalid_d  = 1'b1;
         araddr_d   = fetch_pc_q;
         fetch_pc_d = fetch_pc_q + STEP;
      end else begin
         arvalid_d = 1'b0;
      end

      // A request still waiting on arready belongs to the old stream and is dropped too.
      if (redirect) begin
         fetch_pc_d = redirect_base;
         resp_pc_d  = redirect_base;
         drop_cnt_d = outstanding_d + CW'(hold);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         arvalid_q     <= 1'b0;
         araddr_q      <= RESET_PC;
         fetch_pc_q    <= RESET_PC;
         resp_pc_q     <= RESET_PC;
         outstanding_q <= '0;
         drop_cnt_q    <= '0;
      end else begin
         arvalid_q     <= arvalid_d;
         araddr_q      <= araddr_d;
         fetch_pc_q    <= fetch_pc_d;
         resp_pc_q     <= resp_pc_d;
         outstanding_q <= outstanding_d;
         drop_cnt_q    <= drop_cnt_d;
      end
   end

   ifu_fifo #(
      .WIDTH ($bits(entry_t)),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .clear (redirect),
      .push  (push),
      .wdata (wr_entry),
      .pop   (pop),
      .rdata (rd_entry),
      .count (fifo_count)
   );

   assign out_valid = (fifo_count != '0);
   assign out_pc    = rd_entry.pc;
   assign out_inst  = rd_entry.inst;
   assign out_fault = rd_entry.fault;

   assign arvalid = arvalid_q;
   assign araddr  = araddr_q;
   assign arid    = AXI_ID;
   assign arlen   = 8'd0;
   assign arsize  = axi_size(INST_W);
   assign arburst = AXI_BURST_INCR;
   assign rready  = 1'b1;

endmodule
`default_nettype wire

// File: tb/tb_ifu_prefetch_queue.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_ifu_prefetch_queue : directed bench with a one-cycle AXI memory model (rdata = ~addr)
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_ifu_prefetch_queue;

   logic        clk = 1'b0;
   logic        rst, redirect, stall, out_ready;
   logic [31:0] redirect_pc;
   logic        out_valid, out_fault;
   logic [31:0] out_pc, out_inst;
   logic        arvalid, arready;
   logic [31:0] araddr;
   logic [3:0]  arid;
   logic [7:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst;
   logic        rvalid, rready, rlast;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic [3:0]  rid;

   logic        mem_en;
   logic [31:0] err_pc;
   logic [31:0] rq[$];
   logic [31:0] ar_log[$];

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   ifu_prefetch_queue dut (
      .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc), .stall(stall),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
      .out_fault(out_fault), .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid),
      .arlen(arlen), .arsize(arsize), .arburst(arburst), .rvalid(rvalid), .rready(rready),
      .rdata(rdata), .rresp(rresp), .rlast(rlast), .rid(rid)
   );

   // Memory: answers each accepted AR in order, one cycle later, while mem_en is set.
   initial begin
      logic        ar_fire, r_fire, in_rst;
      logic [31:0] a;
      rvalid = 1'b0; rdata = '0; rresp = 2'b00; rlast = 1'b1; rid = 4'd0;
      forever begin
         @(negedge clk);
         ar_fire = arvalid && arready;
         a       = araddr;
         r_fire  = rvalid && rready;
         in_rst  = rst;
         @(posedge clk);
         #2;
         if (in_rst) begin
            rq.delete();
         end else begin
            if (r_fire) void'(rq.pop_front());
            if (ar_fire) begin
               rq.push_back(a);
               ar_log.push_back(a);
            end
         end
         rvalid = mem_en && (rq.size() > 0);
         if (rq.size() > 0) begin
            rdata = ~rq[0];
            rresp = (rq[0] == err_pc) ? 2'b10 : 2'b00;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; redirect = 1'b0; redirect_pc = '0; stall = 1'b0;
      out_ready = 1'b1; arready = 1'b1; mem_en = 1'b1; err_pc = 32'hFFFF_FFFF;
      tick();
      tick();
      ar_log.delete();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      rst = 1'b1;
      tick();
      n_checks++;
      if (arvalid !== 1'b0 || out_valid !== 1'b0 || rready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_state: arvalid=%b out_valid=%b rready=%b, expected 0 0 1", arvalid, out_valid, rready);
      end
      rst = 1'b0;
      tick();
      n_checks++;
      if (arvalid !== 1'b1 || araddr !== 32'h8000_0000) begin
         n_fail++;
         $display("FAIL reset_first_ar: arvalid=%b araddr=%h, expected 1 80000000", arvalid, araddr);
      end
      n_checks++;
      if (arid !== 4'd0 || arlen !== 8'd0 || arsize !== 3'd2 || arburst !== 2'b01) begin
         n_fail++;
         $display("FAIL ar_fields: arid=%h arlen=%h arsize=%h arburst=%h, expected 0 0 2 1", arid, arlen, arsize, arburst);
      end
   endtask

   task automatic test_stream();
      logic [31:0] exp;
      int n;
      bit ok;
      do_reset();
      exp = 32'h8000_0000;
      n = 0;
      for (int c = 0; c < 30; c++) begin
         tick();
         if (out_valid && out_ready) begin
            n_checks++;
            if (out_pc !== exp || out_inst !== ~exp || out_fault !== 1'b0) begin
               n_fail++;
               $display("FAIL stream_word: pc=%h inst=%h fault=%b, expected pc=%h inst=%h fault=0", out_pc, out_inst, out_fault, exp, ~exp);
            end
            exp += 32'd4;
            n++;
         end
      end
      n_checks++;
      if (n !== 28) begin
         n_fail++;
         $display("FAIL stream_rate: %0d words in 30 cycles, expected 28", n);
      end
      ok = (ar_log.size() >= 4);
      if (ok) begin
         for (int i = 0; i < 4; i++) begin
            if (ar_log[i] !== 32'h8000_0000 + 32'(4 * i)) ok = 1'b0;
         end
      end
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL ar_order: %0d ARs logged, first %h, expected 80000000,04,08,0c in order", ar_log.size(), (ar_log.size() > 0) ? ar_log[0] : 32'hx);
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] exp;
      int got;
      do_reset();
      out_ready = 1'b0;
      repeat (20) tick();
      n_checks++;
      if (ar_log.size() !== 4 || arvalid !== 1'b0 || out_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL full_credit: ars=%0d arvalid=%b out_valid=%b, expected 4 0 1", ar_log.size(), arvalid, out_valid);
      end
      out_ready = 1'b1;
      exp = 32'h8000_0000;
      got = 0;
      for (int c = 0; c < 20 && got < 4; c++) begin
         if (out_valid) begin
            n_checks++;
            if (out_pc !== exp || out_inst !== ~exp) begin
               n_fail++;
               $display("FAIL full_drain: pc=%h inst=%h, expected pc=%h inst=%h", out_pc, out_inst, exp, ~exp);
            end
            exp += 32'd4;
            got++;
         end
         tick();
      end
      n_checks++;
      if (got !== 4) begin
         n_fail++;
         $display("FAIL full_drain_count: %0d words, expected 4", got);
      end
   endtask

   task automatic test_redirect_drop();
      logic [31:0] exp;
      int got;
      do_reset();
      mem_en = 1'b0;
      repeat (6) tick();
      n_checks++;
      if (ar_log.size() !== 2 || arvalid !== 1'b0) begin
         n_fail++;
         $display("FAIL max_out: ars=%0d arvalid=%b, expected 2 0", ar_log.size(), arvalid);
      end
      redirect = 1'b1;
      redirect_pc = 32'h8000_1003;
      tick();
      redirect = 1'b0;
      mem_en = 1'b1;
      exp = 32'h8000_1000;
      got = 0;
      for (int c = 0; c < 40 && got < 2; c++) begin
         if (out_valid) begin
            n_checks++;
            if (out_pc !== exp || out_inst !== ~exp) begin
               n_fail++;
               $display("FAIL redirect_drop: pc=%h inst=%h, expected pc=%h inst=%h", out_pc, out_inst, exp, ~exp);
            end
            exp += 32'd4;
            got++;
         end
         tick();
      end
      n_checks++;
      if (got !== 2) begin
         n_fail++;
         $display("FAIL redirect_drop_count: %0d words, expected 2", got);
      end
   endtask

   task automatic test_redirect_pending();
      int got;
      do_reset();
      arready = 1'b0;
      tick();
      redirect = 1'b1;
      redirect_pc = 32'h8000_2000;
      tick();
      redirect = 1'b0;
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if (arvalid !== 1'b1 || araddr !== 32'h8000_0000) begin
            n_fail++;
            $display("FAIL ar_hold: cycle %0d arvalid=%b araddr=%h, expected 1 80000000", i, arvalid, araddr);
         end
         tick();
      end
      arready = 1'b1;
      got = 0;
      for (int c = 0; c < 40 && got < 1; c++) begin
         if (out_valid) begin
            n_checks++;
            if (out_pc !== 32'h8000_2000) begin
               n_fail++;
               $display("FAIL pending_drop: pc=%h, expected 80002000", out_pc);
            end
            got++;
         end
         tick();
      end
      n_checks++;
      if (got !== 1 || ar_log.size() < 2 || ar_log[0] !== 32'h8000_0000 || ar_log[1] !== 32'h8000_2000) begin
         n_fail++;
         $display("FAIL pending_ar_seq: words=%0d ars=%0d, expected 1 word and ARs 80000000 then 80002000", got, ar_log.size());
      end
   endtask

   task automatic test_fault();
      logic [31:0] exp;
      int got;
      do_reset();
      err_pc = 32'h8000_0008;
      exp = 32'h8000_0000;
      got = 0;
      for (int c = 0; c < 30 && got < 4; c++) begin
         if (out_valid) begin
            n_checks++;
            if (out_pc !== exp || out_fault !== (exp == 32'h8000_0008)) begin
               n_fail++;
               $display("FAIL fault_flag: pc=%h fault=%b, expected pc=%h fault=%b", out_pc, out_fault, exp, (exp == 32'h8000_0008));
            end
            exp += 32'd4;
            got++;
         end
         tick();
      end
      n_checks++;
      if (got !== 4) begin
         n_fail++;
         $display("FAIL fault_count: %0d words, expected 4", got);
      end
   endtask

   task automatic test_stall_reset();
      logic [31:0] exp;
      int got;
      do_reset();
      out_ready = 1'b0;
      repeat (10) tick();
      stall = 1'b1;
      out_ready = 1'b1;
      exp = 32'h8000_0000;
      got = 0;
      for (int c = 0; c < 10; c++) begin
         if (out_valid) begin
            n_checks++;
            if (out_pc !== exp) begin
               n_fail++;
               $display("FAIL stall_drain: pc=%h, expected %h", out_pc, exp);
            end
            exp += 32'd4;
            got++;
         end
         tick();
      end
      n_checks++;
      if (ar_log.size() !== 4 || got !== 4 || out_valid !== 1'b0 || arvalid !== 1'b0) begin
         n_fail++;
         $display("FAIL stall_hold: ars=%0d words=%0d out_valid=%b arvalid=%b, expected 4 4 0 0", ar_log.size(), got, out_valid, arvalid);
      end
      stall = 1'b0;
      tick();
      n_checks++;
      if (arvalid !== 1'b1 || araddr !== 32'h8000_0010) begin
         n_fail++;
         $display("FAIL stall_resume: arvalid=%b araddr=%h, expected 1 80000010", arvalid, araddr);
      end
      repeat (2) tick();
      rst = 1'b1;
      tick();
      n_checks++;
      if (arvalid !== 1'b0 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL midrun_reset: arvalid=%b out_valid=%b, expected 0 0", arvalid, out_valid);
      end
      rst = 1'b0;
      tick();
      n_checks++;
      if (arvalid !== 1'b1 || araddr !== 32'h8000_0000) begin
         n_fail++;
         $display("FAIL midrun_restart: arvalid=%b araddr=%h, expected 1 80000000", arvalid, araddr);
      end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect_drop();
      test_redirect_pending();
      test_fault();
      test_stall_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
